// File: rtl/ex_operand_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ex_operand_stage                                             |
// | Description : EX operand register with forwarding, load-use hazard and     |
// |               writeback snoop. Optional macro: EX_OPERAND_FORWARDING_EN.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+

package lc3b_types;
    typedef enum logic [2:0] {
        alu_add  = 3'd0,
        alu_and  = 3'd1,
        alu_not  = 3'd2,
        alu_pass = 3'd3,
        alu_sll  = 3'd4,
        alu_srl  = 3'd5,
        alu_sra  = 3'd6
    } lc3b_aluop;
endpackage

module ex_operand_stage
    import lc3b_types::*;
(
    input  logic        clk,
    input  logic        rst,
    // ID stage
    input  logic        id_valid,
    input  lc3b_aluop   id_aluop,
    input  logic [2:0]  id_sr1,
    input  logic [2:0]  id_sr2,
    input  logic [15:0] id_sr1_val,
    input  logic [15:0] id_sr2_val,
    input  logic        id_use_imm,
    input  logic [15:0] id_imm,
    input  logic [2:0]  id_dest,
    input  logic        id_regwrite,
    input  logic        id_is_load,
    output logic        id_ready,
    // control
    input  logic        flush,
    input  logic        mem_stall,
    // forwarding sources
    input  logic        exmem_valid,
    input  logic        exmem_regwrite,
    input  logic        exmem_is_load,
    input  logic [2:0]  exmem_dest,
    input  logic [15:0] exmem_result,
    input  logic        memwb_valid,
    input  logic        memwb_regwrite,
    input  logic [2:0]  memwb_dest,
    input  logic [15:0] memwb_result,
    // EX outputs
    output logic        ex_valid,
    output lc3b_aluop   ex_aluop,
    output logic [15:0] ex_a,
    output logic [15:0] ex_b,
    output logic [2:0]  ex_dest,
    output logic        ex_regwrite,
    output logic        ex_is_load
);

    logic        r_valid;
    lc3b_aluop   r_aluop;
    logic [2:0]  r_sr1;
    logic [2:0]  r_sr2;
    logic [15:0] r_sr1_val;
    logic [15:0] r_sr2_val;
    logic        r_use_imm;
    logic [15:0] r_imm;
    logic [2:0]  r_dest;
    logic        r_regwrite;
    logic        r_is_load;

    logic        w_ex_wr;
    logic        w_wb_wr;
    logic        w_ex_m1;
    logic        w_ex_m2;
    logic        w_wb_m1;
    logic        w_wb_m2;
    logic        w_hazard;
    logic        w_adv;
    logic [15:0] w_a;
    logic [15:0] w_b_src;

    assign w_ex_wr = exmem_valid & exmem_regwrite;
    assign w_wb_wr = memwb_valid & memwb_regwrite;

    // Matches are gated by r_valid so an empty register never forwards or stalls.
    assign w_ex_m1 = r_valid & w_ex_wr & (exmem_dest == r_sr1);
    assign w_ex_m2 = r_valid & ~r_use_imm & w_ex_wr & (exmem_dest == r_sr2);
    assign w_wb_m1 = r_valid & w_wb_wr & (memwb_dest == r_sr1);
    assign w_wb_m2 = r_valid & ~r_use_imm & w_wb_wr & (memwb_dest == r_sr2);

`ifdef EX_OPERAND_FORWARDING_EN
    assign w_hazard = exmem_is_load & (w_ex_m1 | w_ex_m2);

    always_comb begin
        w_a     = r_sr1_val;
        w_b_src = r_sr2_val;
        if (w_ex_m1 & ~exmem_is_load) begin
            w_a = exmem_result;
        end else if (w_wb_m1) begin
            w_a = memwb_result;
        end
        if (w_ex_m2 & ~exmem_is_load) begin
            w_b_src = exmem_result;
        end else if (w_wb_m2) begin
            w_b_src = memwb_result;
        end
    end
`else
    // Without forwarding, wait until the producer has left both later stages;
    // the writeback snoop captures the value on its way through MEM/WB.
    assign w_hazard = w_ex_m1 | w_ex_m2 | w_wb_m1 | w_wb_m2;
    assign w_a      = r_sr1_val;
    assign w_b_src  = r_sr2_val;

    logic w_unused_fwd;
    assign w_unused_fwd = ^{exmem_is_load, exmem_result};
`endif

    assign w_adv    = ~mem_stall & (~r_valid | ~w_hazard);
    assign id_ready = w_adv & ~flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_aluop    <= alu_add;
            r_sr1      <= 3'd0;
            r_sr2      <= 3'd0;
            r_sr1_val  <= 16'd0;
            r_sr2_val  <= 16'd0;
            r_use_imm  <= 1'b0;
            r_imm      <= 16'd0;
            r_dest     <= 3'd0;
            r_regwrite <= 1'b0;
            r_is_load  <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_adv) begin
            r_valid    <= id_valid;
            r_aluop    <= id_aluop;
            r_sr1      <= id_sr1;
            r_sr2      <= id_sr2;
            r_sr1_val  <= id_sr1_val;
            r_sr2_val  <= id_sr2_val;
            r_use_imm  <= id_use_imm;
            r_imm      <= id_imm;
            r_dest     <= id_dest;
            r_regwrite <= id_regwrite;
            r_is_load  <= id_is_load;
        end else begin
            if (w_wb_wr && (memwb_dest == r_sr1)) begin
                r_sr1_val <= memwb_result;
            end
            if (w_wb_wr && (memwb_dest == r_sr2)) begin
                r_sr2_val <= memwb_result;
            end
        end
    end

    assign ex_valid    = r_valid & ~w_hazard;
    assign ex_aluop    = r_aluop;
    assign ex_a        = w_a;
    assign ex_b        = r_use_imm ? r_imm : w_b_src;
    assign ex_dest     = r_dest;
    assign ex_regwrite = r_regwrite;
    assign ex_is_load  = r_is_load;

endmodule

`default_nettype wire
